dmem_write_ctrl: RTL
====================

Name: dmem_write_ctrl

Overview:
- Write-direction counterpart to the MDR load path: drives a 16-bit MDR value out to the byte-wide data memory.
- On a dmem_write request from the control unit, it latches MDR and AR and issues one or two byte writes (low byte at addr, high byte at addr+1).
- It holds each write strobe for a programmable number of cycles, then reports completion so the control unit can leave its store state.

Parameters:
- ADDR_W, 8, data memory address width; addresses wrap modulo 2^ADDR_W.
- WR_CYCLES, 2, cycles mem_we is held per byte (legal 1..15).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- dmem_write  input  1  store request from control unit, sampled in IDLE only
- dmem_read  input  1  load request from control unit, used for conflict detection only
- store_word  input  1  1 = write 2 bytes, 0 = write low byte only; sampled with dmem_write
- MDR_out  input  16  data to store, latched on accept
- AR_out  input  16  byte address, low ADDR_W bits latched on accept
- mem_addr  output  ADDR_W  data memory address
- mem_wdata  output  8  data memory write byte
- mem_we  output  1  data memory write enable
- busy  output  1  high from accept until the cycle before done
- done  output  1  one-cycle pulse when the store completes
- conflict  output  1  one-cycle pulse when a request is rejected because dmem_read is also high

Behaviour:
- Reset (async, any state): state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, conflict=0, counter=0, latches=0. An in-flight store is abandoned with no done pulse.
- Outputs are registered. Memory sees the new addr, wdata and we together in the same cycle.
- FSM states: IDLE, WR_LO, WR_HI, DONE.
- IDLE:
  - If dmem_write=1 and dmem_read=0: latch data=MDR_out, addr=AR_out[ADDR_W-1:0] and word=store_word. Next cycle, enter WR_LO with mem_addr=addr, mem_wdata=data[7:0], mem_we=1, busy=1 and cnt=WR_CYCLES-1.
  - If dmem_write=1 and dmem_read=1: no store; conflict=1 for the next cycle only; stay in IDLE.
- WR_LO: mem_we held high.
  - cnt≠0: decrement.
  - cnt=0 and word=1: enter WR_HI with mem_addr=addr+1 (wraps, e.g. 0xFF→0x00 for ADDR_W=8), mem_wdata=data[15:8], mem_we=1 and cnt reloaded. mem_we does not drop between the two bytes.
  - cnt=0 and word=0: enter DONE.
- WR_HI: same counting as WR_LO; at cnt=0, enter DONE.
- DONE (one cycle): mem_we=0, busy=0, done=1. Next state is IDLE.
- Latency:
  - Byte store: mem_we is high for exactly WR_CYCLES cycles; done asserts 1+WR_CYCLES cycles after the request edge.
  - Word store: mem_we is high for exactly 2·WR_CYCLES cycles; done asserts 1+2·WR_CYCLES cycles after the request edge.
- Ignored inputs:
  - dmem_write outside IDLE (including DONE) is ignored and not queued. A level held high restarts a new store on the first IDLE cycle.
  - MDR_out and AR_out changes after accept do not affect the store in progress.
  - dmem_read outside IDLE has no effect.
- Outside active write states, mem_addr and mem_wdata hold their last values; only mem_we is guaranteed 0.

Test Plan:
- Byte store, WR_CYCLES=2: MDR_out=0xA55A, AR_out=0x0010, store_word=0, pulse dmem_write → mem_we high 2 cycles with addr 0x10, wdata 0x5A; done pulses once 3 cycles after request; busy high 2 cycles.
- Word store with wrap, ADDR_W=8: MDR_out=0x1234, AR_out=0x00FF, store_word=1 → (0xFF, 0x34) for 2 cycles, then (0x00, 0x12) for 2 cycles; mem_we continuous for 4 cycles; done at cycle 5.
- Conflict: dmem_write=1 and dmem_read=1 in IDLE → conflict pulses 1 cycle; mem_we and busy stay 0; no done.
- Request during busy / input change: second dmem_write pulse and MDR_out change mid-word store → only the original bytes are written; exactly one done. Then hold dmem_write high through DONE → new store starts on the next IDLE cycle.
- Async reset mid-store: assert reset during WR_HI between clock edges → mem_we, busy and done go 0 immediately. After release, a new byte store completes normally.
- WR_CYCLES=1 word store → mem_we high exactly 2 cycles; done 3 cycles after request.

Source files
------------

// File: rtl/dmem_write_ctrl.sv
// dmem_write_ctrl: write path from the 16-bit MDR to the byte-wide data memory.
// A store request latches MDR and AR. The block then writes one byte (low at
// addr) or two bytes (low at addr, high at addr+1). Each write strobe is held
// for WR_CYCLES clocks. The block then pulses done for one cycle.
// WR_CYCLES must lie in 1..15 because the hold counter is 4 bits wide.

module dmem_write_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int WR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dmem_write,
    input  logic              dmem_read,
    input  logic              store_word,
    input  logic [15:0]       MDR_out,
    input  logic [15:0]       AR_out,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              conflict
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Counter reload: the strobe is held WR_CYCLES cycles, counting down to 0.
    localparam logic [3:0] CNT_RELOAD = 4'(WR_CYCLES - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [7:0]        data_hi_q;   // only the high byte is needed after accept
    logic [ADDR_W-1:0] addr_q;
    logic              word_q;

    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              mem_we_q;
    logic              busy_q;
    logic              done_q;
    logic              conflict_q;

    // Address of the high byte; the sum drops its carry, so it wraps modulo 2^ADDR_W.
    logic [ADDR_W-1:0] addr_hi_d;
    assign addr_hi_d = addr_q + ADDR_W'(1);

    // The address bits above ADDR_W are intentionally ignored.
    if (ADDR_W < 16) begin : g_unused_ar
        logic unused_ar_hi;
        assign unused_ar_hi = ^AR_out[15:ADDR_W];
    end

    // Store sequencer with registered memory-side and handshake outputs.
    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            data_hi_q   <= '0;
            addr_q      <= '0;
            word_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            // Pulses last one cycle unless a state below re-asserts them.
            done_q     <= 1'b0;
            conflict_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    if (dmem_write) begin
                        if (dmem_read) begin
                            conflict_q <= 1'b1;
                        end else begin
                            data_hi_q   <= MDR_out[15:8];
                            addr_q      <= AR_out[ADDR_W-1:0];
                            word_q      <= store_word;
                            mem_addr_q  <= AR_out[ADDR_W-1:0];
                            mem_wdata_q <= MDR_out[7:0];
                            mem_we_q    <= 1'b1;
                            busy_q      <= 1'b1;
                            cnt_q       <= CNT_RELOAD;
                            state_q     <= ST_WR_LO;
                        end
                    end
                end

                ST_WR_LO: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (word_q) begin
                        // mem_we stays high so the two byte writes are back to back.
                        mem_addr_q  <= addr_hi_d;
                        mem_wdata_q <= data_hi_q;
                        cnt_q       <= CNT_RELOAD;
                        state_q     <= ST_WR_HI;
                    end else begin
                        mem_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end

                ST_WR_HI: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        mem_we_q <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    // A request seen here is dropped; a held level is taken in IDLE.
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign conflict  = conflict_q;

endmodule
